// File: rtl/enc_pkg.sv
// Shared types for the round-robin arbiter and the downstream one-hot encoder.
package enc_pkg;
  localparam int REQ_W = 4;

  typedef logic [REQ_W-1:0] onehot_t;
  typedef logic [1:0]       idx_t;

  // Index of the set bit of a one-hot word.
  function automatic idx_t oh2idx(input onehot_t oh);
    oh2idx = {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit searching upward from last+1, wrapping 3->0.
module rr_pick
  import enc_pkg::*;
(
  input  onehot_t req,
  input  idx_t    last,
  output onehot_t win_oh,
  output idx_t    win_idx,
  output logic    win_any
);
  idx_t cand;

  always_comb begin
    win_any = 1'b0;
    win_idx = last;
    cand    = last;
    // last itself is visited last (i == REQ_W wraps back to it)
    for (int i = 1; i <= REQ_W; i++) begin
      cand = last + idx_t'(i);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_oh = win_any ? (onehot_t'(1) << win_idx) : '0;
endmodule

// File: rtl/rr_onehot_arb.sv
// Registered one-hot round-robin arbiter with valid/ready grant handshake.
// Define ARB_LOCK_EN to add arb_lock: the owner keeps the grant across transfers.
module rr_onehot_arb
  import enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  input  logic         gnt_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic         arb_lock
`endif
);
  onehot_t gnt_q;
  logic    vld_q;
  idx_t    last_q;

  logic    xfer, arb, lock_hold, win_any;
  idx_t    gnt_idx, pick_last, win_idx;
  onehot_t win_oh;

  assign gnt_idx   = oh2idx(gnt_q);
  assign xfer      = vld_q & gnt_ready;
  assign arb       = ~vld_q | xfer;
  // same-edge arbitration sees the index being transferred now
  assign pick_last = xfer ? gnt_idx : last_q;

`ifdef ARB_LOCK_EN
  assign lock_hold = xfer & arb_lock & |(onehot_t'(req) & gnt_q);
`else
  assign lock_hold = 1'b0;
`endif

  rr_pick u_pick (
    .req     (onehot_t'(req)),
    .last    (pick_last),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 2'd3;
    end else begin
      if (xfer) last_q <= gnt_idx;
      if (arb && !lock_hold) begin
        gnt_q <= win_oh;
        vld_q <= win_any;
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;

  logic unused_win_idx;
  assign unused_win_idx = ^win_idx;
endmodule

// File: tb/tb_rr_onehot_arb.sv
// Scoreboard bench for rr_onehot_arb: expected {gnt_valid,gnt} queued at drive time.
module tb_rr_onehot_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_ready = 1'b0;
  logic       arb_lock = 1'b0;

  logic [4:0] exp_q[$];
  logic [4:0] exp;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  rr_onehot_arb #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready)
`ifdef ARB_LOCK_EN
    ,
    .arb_lock  (arb_lock)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; gnt_ready = 1'b1;
    exp_q.push_back(5'b0_0000);
    exp_q.push_back(5'b0_0000);
    repeat (2) begin
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL reset: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_rr_sequence();
    rst_n = 1'b1; req = 4'b1111; gnt_ready = 1'b1;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(5'b1_0001);
    exp_q.push_back(5'b1_0010);
    exp_q.push_back(5'b1_0100);
    exp_q.push_back(5'b1_1000);
    exp_q.push_back(5'b1_0001);
    repeat (5) begin
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL rr_sequence: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
      end
    end
    req = 4'b0000;
    exp_q.push_back(5'b0_0000);
    tick();
    exp = exp_q.pop_front();
    n_chk++;
    if ({gnt_valid, gnt} !== exp) begin
      n_fail++;
      $display("FAIL rr_drain: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
    end
  endtask

  // last=0 here; grant must be held through a stall even after req drops
  task automatic test_stall();
    req = 4'b0100; gnt_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = 4'b0000;
      exp_q.push_back(5'b1_0100);
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL stall c%0d: got %b/%b want %b/%b", c, gnt_valid, gnt, exp[4], exp[3:0]);
      end
    end
    gnt_ready = 1'b1;
    exp_q.push_back(5'b0_0000);
    exp_q.push_back(5'b0_0000);
    repeat (2) begin
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL stall_release: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
      end
    end
  endtask

  // last=2: grant 1000, transfer it with 1001 pending -> wraps to 0001
  task automatic test_wrap();
    req = 4'b1000; gnt_ready = 1'b1;
    exp_q.push_back(5'b1_1000);
    tick();
    exp = exp_q.pop_front();
    n_chk++;
    if ({gnt_valid, gnt} !== exp) begin
      n_fail++;
      $display("FAIL wrap_setup: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
    end
    req = 4'b1001;
    exp_q.push_back(5'b1_0001);
    tick();
    exp = exp_q.pop_front();
    n_chk++;
    if ({gnt_valid, gnt} !== exp) begin
      n_fail++;
      $display("FAIL wrap: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
    end
    req = 4'b0000;
    exp_q.push_back(5'b0_0000);
    tick();
    exp = exp_q.pop_front();
    n_chk++;
    if ({gnt_valid, gnt} !== exp) begin
      n_fail++;
      $display("FAIL wrap_drain: got %b/%b want %b/%b", gnt_valid, gnt, exp[4], exp[3:0]);
    end
  endtask

  // last=0: pending 0010 dropped by reset; after release, req[0] side has priority again
  task automatic test_reset_mid();
    req = 4'b0010; gnt_ready = 1'b0;
    exp_q.push_back(5'b1_0010);
    exp_q.push_back(5'b0_0000);
    exp_q.push_back(5'b1_0010);
    exp_q.push_back(5'b0_0000);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) rst_n = 1'b0;
      if (c == 2) begin rst_n = 1'b1; req = 4'b0110; end
      if (c == 3) begin req = 4'b0000; gnt_ready = 1'b1; end
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %b/%b want %b/%b", c, gnt_valid, gnt, exp[4], exp[3:0]);
      end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b0011; gnt_ready = 1'b1; arb_lock = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) arb_lock = 1'b0;
      exp_q.push_back(c == 5 ? 5'b1_0010 : 5'b1_0001);
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL lock c%0d: got %b/%b want %b/%b", c, gnt_valid, gnt, exp[4], exp[3:0]);
      end
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  // Independent behavioural model plus per-requester wait counters.
  task automatic test_random();
    logic [3:0] m_gnt;
    logic       m_vld;
    int         m_last;
    int         wait_cnt[4];
    int         wi;
    logic       found;
    rst_n = 1'b0; arb_lock = 1'b0; tick(); rst_n = 1'b1;
    m_gnt = '0; m_vld = 1'b0; m_last = 3;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      req       = 4'($urandom_range(0, 15));
      gnt_ready = ($urandom_range(0, 3) != 0);
      // starvation bookkeeping on the edge about to happen
      for (int k = 0; k < 4; k++) begin
        if (!req[k]) wait_cnt[k] = 0;
        else if (m_vld && gnt_ready && !m_gnt[k]) wait_cnt[k]++;
      end
      if (m_vld && gnt_ready) begin
        for (int k = 0; k < 4; k++) if (m_gnt[k]) m_last = k;
      end
      if (!m_vld || gnt_ready) begin
        found = 1'b0; m_gnt = '0;
        for (int s = 1; s <= 4; s++) begin
          wi = (m_last + s) % 4;
          if (!found && req[wi]) begin found = 1'b1; m_gnt[wi] = 1'b1; end
        end
        m_vld = found;
      end
      for (int k = 0; k < 4; k++) if (m_gnt[k]) wait_cnt[k] = 0;
      exp_q.push_back({m_vld, m_gnt});
      tick();
      exp = exp_q.pop_front();
      n_chk++;
      if ({gnt_valid, gnt} !== exp) begin
        n_fail++;
        $display("FAIL random c%0d: got %b/%b want %b/%b", c, gnt_valid, gnt, exp[4], exp[3:0]);
      end
      n_chk++;
      if ((gnt_valid && !$onehot(gnt)) || (!gnt_valid && gnt !== 4'b0)) begin
        n_fail++;
        $display("FAIL onehot c%0d: got %b/%b want one-hot iff valid", c, gnt_valid, gnt);
      end
      for (int k = 0; k < 4; k++) begin
        if (wait_cnt[k] > 3) begin
          n_chk++;
          n_fail++;
          $display("FAIL starve req%0d: waited %0d want <=3", k, wait_cnt[k]);
          wait_cnt[k] = 0;
        end
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_rr_sequence();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
